// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and helpers for the MEM pipeline stage
package mem_stage_pkg;
  typedef enum logic [3:0] {MEM_OP_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW} mem_op_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    mem_op_t     mem_op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic [31:0] alu_result;
  } mem_params_t;
  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    mem_op_t     mem_op;
  } wb_params_t;
  function automatic logic is_load(mem_op_t op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction
  function automatic logic is_store(mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction
  function automatic logic is_misaligned(mem_op_t op, logic [1:0] a);
    return (op inside {LH, LHU, SH} && a[0]) || (op inside {LW, SW} && a != 2'd0);
  endfunction
  function automatic logic [3:0] byte_en(mem_op_t op, logic [1:0] a);
    return op inside {LB, LBU, SB} ? 4'(4'b0001 << a) :
           op inside {LH, LHU, SH} ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects and extends the addressed byte/halfword of a load word
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mem_op_t     mem_op,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = 8'(rdata >> {addr_lo, 3'b000});
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result = mem_op == LB  ? {{24{b[7]}}, b} :
             mem_op == LBU ? {24'd0, b} :
             mem_op == LH  ? {{16{h[15]}}, h} :
             mem_op == LHU ? {16'd0, h} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a single-outstanding req/ack data bus
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  mem_params_t     mem_params_in,
  output logic            stall,
  output logic            fault,
  output wb_params_t      wb_params_out,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-3:0] dbus_addr,
  output logic [3:0]      dbus_be,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_ack,
  input  logic [XLEN-1:0] dbus_rdata
);
  state_t      state, state_nx;
  logic [31:0] rdata_q, load_res;
  logic        mem_v, mis;
  mem_op_t     op;
  assign op = mem_params_in.mem_op;
  load_align u_align (
    .rdata  (rdata_q),
    .addr_lo(mem_params_in.addr[1:0]),
    .mem_op (op),
    .result (load_res)
  );
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    mem_v    = op != MEM_OP_NONE;
    mis      = is_misaligned(op, mem_params_in.addr[1:0]);
    state_nx = state == IDLE ? (mem_v && !mis ? BUSY : IDLE) :
               state == BUSY ? (dbus_ack ? DONE : BUSY) : IDLE;
    stall    = state == BUSY || (state == IDLE && mem_v && !mis);
    fault    = state == IDLE && mem_v && mis;
    wb_params_out = '0;
    if (state == IDLE && !mem_v) begin
      wb_params_out.rd_addr = mem_params_in.rd_addr;
      wb_params_out.rd_data = mem_params_in.alu_result;
    end else if (state == DONE) begin
      // EX/MEM is frozen until this cycle, so the op fields still describe the access
      wb_params_out.mem_op  = op;
      wb_params_out.rd_addr = is_store(op) ? 5'd0 : mem_params_in.rd_addr;
      wb_params_out.rd_data = is_store(op) ? 32'd0 : load_res;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE && state_nx == BUSY) begin
        dbus_req   <= 1'b1;
        dbus_we    <= is_store(op);
        dbus_addr  <= mem_params_in.addr[31:2];
        dbus_be    <= byte_en(op, mem_params_in.addr[1:0]);
        dbus_wdata <= op == SB ? {4{mem_params_in.store_data[7:0]}} :
                      op == SH ? {2{mem_params_in.store_data[15:0]}} : mem_params_in.store_data;
      end
      if (state == BUSY && dbus_ack) begin
        dbus_req <= 1'b0;
        rdata_q  <= dbus_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a transaction-level model
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic        clk, rst_n;
  mem_params_t mem_params_in;
  logic        stall, fault, dbus_req, dbus_we, dbus_ack;
  wb_params_t  wb_params_out;
  logic [29:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata, dbus_rdata;
  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .mem_params_in(mem_params_in), .stall(stall), .fault(fault),
    .wb_params_out(wb_params_out), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  bit chk_en = 0;
  logic exp_stall, exp_fault, exp_req, exp_bus, exp_wd, exp_we;
  logic [29:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata;
  wb_params_t  exp_wb;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("stall", 64'(stall), 64'(exp_stall));
    chk("fault", 64'(fault), 64'(exp_fault));
    chk("dbus_req", 64'(dbus_req), 64'(exp_req));
    chk("wb_params", 64'(wb_params_out), 64'(exp_wb));
    if (exp_bus) begin
      chk("dbus_we", 64'(dbus_we), 64'(exp_we));
      chk("dbus_addr", 64'(dbus_addr), 64'(exp_addr));
      chk("dbus_be", 64'(dbus_be), 64'(exp_be));
    end
    if (exp_wd) chk("dbus_wdata", 64'(dbus_wdata), 64'(exp_wdata));
  end
  function automatic mem_params_t mk(mem_op_t op, logic [31:0] a, logic [31:0] sd, logic [4:0] rd, logic [31:0] alu);
    mem_params_t p;
    p.mem_op = op; p.addr = a; p.store_data = sd; p.rd_addr = rd; p.alu_result = alu;
    return p;
  endfunction
  function automatic wb_params_t mk_wb(logic [4:0] rd, logic [31:0] d, mem_op_t op);
    wb_params_t w;
    w.rd_addr = rd; w.rd_data = d; w.mem_op = op;
    return w;
  endfunction
  function automatic bit m_store(mem_op_t op);
    return op == SB || op == SH || op == SW;
  endfunction
  function automatic bit m_mis(mem_op_t op, logic [1:0] a);
    if (op == LH || op == LHU || op == SH) return a % 2 != 0;
    if (op == LW || op == SW) return a != 0;
    return 0;
  endfunction
  function automatic logic [3:0] m_be(mem_op_t op, logic [1:0] a);
    if (op == LB || op == LBU || op == SB) return 4'(1 << a);
    if (op == LH || op == LHU || op == SH) return a >= 2 ? 4'hC : 4'h3;
    return 4'hF;
  endfunction
  function automatic logic [31:0] m_wdata(mem_op_t op, logic [31:0] sd);
    if (op == SB) return (sd & 32'hFF) * 32'h01010101;
    if (op == SH) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction
  function automatic logic [31:0] m_load(logic [31:0] w, mem_op_t op, logic [1:0] a);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      LB:  return b >= 128 ? b + 32'hFFFFFF00 : b;
      LBU: return b;
      LH:  return h >= 32768 ? h + 32'hFFFF0000 : h;
      LHU: return h;
      default: return w;
    endcase
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic quiet(logic [31:0] d, logic [4:0] rd);
    exp_stall = 0; exp_fault = 0; exp_req = 0; exp_bus = 0; exp_wd = 0;
    exp_wb = mk_wb(rd, d, MEM_OP_NONE);
  endtask
  // One instruction through MEM; lit overrides the model with hand-computed data/be
  task automatic run_op(mem_params_t p, int dly, logic [31:0] rdw, bit lit, logic [31:0] lit_data, logic [3:0] lit_be);
    mem_op_t op;
    op = p.mem_op;
    mem_params_in = p; dbus_ack = 0; dbus_rdata = $urandom;
    if (op == MEM_OP_NONE) begin
      quiet(lit ? lit_data : p.alu_result, p.rd_addr);
      step();
      return;
    end
    if (m_mis(op, p.addr[1:0])) begin
      quiet(0, 0);
      exp_fault = 1;
      step();
      return;
    end
    quiet(0, 0);
    exp_stall = 1;
    step();
    for (int i = 0; i <= dly; i++) begin
      exp_req = 1; exp_bus = 1; exp_wd = m_store(op);
      exp_we = m_store(op); exp_addr = 30'(p.addr >> 2);
      exp_be = lit ? lit_be : m_be(op, p.addr[1:0]);
      exp_wdata = m_wdata(op, p.store_data);
      dbus_ack = i == dly;
      dbus_rdata = i == dly ? rdw : $urandom;
      step();
    end
    dbus_ack = 0; dbus_rdata = $urandom;
    quiet(0, 0);
    exp_wb = m_store(op) ? mk_wb(0, 0, op) :
             mk_wb(p.rd_addr, lit ? lit_data : m_load(rdw, op, p.addr[1:0]), op);
    step();
  endtask
  initial begin
    rst_n = 0; dbus_ack = 0; dbus_rdata = 0;
    mem_params_in = mk(MEM_OP_NONE, 0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1;
    chk_en = 1;
    // reset while a load waits on the bus
    mem_params_in = mk(LW, 32'h100, 0, 3, 0);
    quiet(0, 0); exp_stall = 1;
    step();
    exp_req = 1; exp_bus = 1; exp_we = 0; exp_addr = 30'h40; exp_be = 4'hF;
    step();
    chk_en = 0; rst_n = 0;
    mem_params_in = mk(MEM_OP_NONE, 0, 0, 9, 32'h77);
    step(); step();
    rst_n = 1; chk_en = 1;
    quiet(32'h77, 9);
    exp_bus = 1; exp_wd = 1; exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
    step();
    dbus_ack = 1; dbus_rdata = 32'hCAFEF00D;
    step();
    dbus_ack = 0;
    step();
    run_op(mk(LW, 32'h1004, 0, 5, 0), 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'hF);
    run_op(mk(LB, 32'h2003, 0, 6, 0), 3, 32'h80FF0000, 1, 32'hFFFFFF80, 4'b1000);
    run_op(mk(LBU, 32'h2003, 0, 6, 0), 3, 32'h80FF0000, 1, 32'h00000080, 4'b1000);
    run_op(mk(SH, 32'h3002, 32'h1234ABCD, 4, 0), 1, 32'h0, 1, 0, 4'b1100);
    run_op(mk(LW, 32'h4002, 0, 8, 0), 0, 0, 0, 0, 0);
    run_op(mk(LH, 32'h10, 0, 2, 0), 0, 32'h00008001, 1, 32'hFFFF8001, 4'b0011);
    run_op(mk(MEM_OP_NONE, 0, 0, 7, 32'h55), 0, 0, 1, 32'h55, 0);
    for (int i = 0; i < 300; i++) begin
      mem_op_t op;
      op = mem_op_t'($urandom_range(0, 8));
      run_op(mk(op, $urandom, $urandom, 5'($urandom), $urandom), $urandom_range(0, 4), $urandom, 0, 0, 0);
    end
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the MINAv2 core, sitting between EX/MEM and the MEM/WB register.
- Executes loads and stores on a single-outstanding data bus with a req/ack handshake, stalling the pipeline until the access completes.
- Aligns and sign- or zero-extends load data.
- Produces the wb_params_t record (rd_addr, rd_data, mem_op) that MEM/WB latches.

Parameters:
- XLEN, 32, data and address width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- mem_params_in  in  struct mem_params_t  {mem_op, addr[31:0], store_data[31:0], rd_addr[4:0], alu_result[31:0]} from EX/MEM
- stall  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM while high
- fault  out  1  one-cycle pulse on a misaligned access
- wb_params_out  out  wb_params_t  to MEM/WB
- dbus_req  out  1  bus request, held until ack
- dbus_we  out  1  1 = write
- dbus_addr  out  30  word address (addr[31:2])
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  store data, lane-replicated
- dbus_ack  in  1  transaction complete
- dbus_rdata  in  32  read data, valid with ack

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state = IDLE. dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata and the captured rdata register are all 0. Reset mid-transaction abandons the access; a late ack in IDLE is ignored.
- IDLE, mem_op == MEM_OP_NONE:
  - wb_params_out = {rd_addr, alu_result, MEM_OP_NONE}, combinational pass-through.
  - stall = 0.
- IDLE, memory op, misaligned (halfword with addr[0] = 1; word with addr[1:0] != 0):
  - No bus request is issued.
  - fault = 1 for that cycle.
  - wb_params_out = {0, 0, MEM_OP_NONE}.
  - stall = 0.
- IDLE, memory op, aligned:
  - stall = 1.
  - wb_params_out = {0, 0, MEM_OP_NONE} (bubble).
  - Next cycle: state = BUSY, with dbus_req/we/addr/be/wdata registered.
- BUSY:
  - stall = 1.
  - Bus outputs held stable while dbus_req = 1 and dbus_ack = 0.
  - On dbus_ack: rdata is captured, dbus_req drops next edge, and state = DONE.
  - Ack in the same cycle that req first rises is legal.
- DONE:
  - stall = 0.
  - wb_params_out = {rd_addr, formatted data, mem_op}. For stores, rd_addr = 0 and rd_data = 0.
  - Next state = IDLE.
  - EX/MEM advances at this edge, so the same op is not re-issued.
- Latency: op presented at cycle 0, req high at cycle 1, ack at cycle k ≥ 1, result at cycle k+1. Minimum memory-op occupancy is 3 cycles.
- Byte enables and store data:
  - SB: be = 1 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{store_data[15:0]}}.
  - SW: be = 4'b1111.
  - Loads: same be values; we = 0.
- Load formatting: select byte/halfword by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- dbus_req never asserts twice for one op; no new request before ack.

Decomposition:
- types package:
  - mem_op_t enum: MEM_OP_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
  - mem_params_t struct.
  - Helper functions is_load and is_store.
- Sub-module load_align: combinational (rdata, addr[1:0], mem_op) -> 32-bit result. It is unit-tested separately.

Test Plan:
1. Reset with rst_n = 0 held for 2 cycles, in BUSY with req high -> after release: dbus_req = 0, stall = 0, state IDLE. A stray ack next cycle produces no output change.
2. LW, addr 0x1004, rd 5, ack on the first req cycle, rdata 0xDEADBEEF -> req in cycle 1; wb_params_out = {5, 0xDEADBEEF, LW} in cycle 2 with stall low; stall high in cycles 0–1.
3. LB and LBU at addr 0x2003, rdata 0x80FF_0000, ack delayed 3 cycles -> LB yields 0xFFFFFF80, LBU yields 0x00000080. Bus outputs stay stable while waiting; be = 4'b1000.
4. SH at addr 0x3002, store_data 0x1234ABCD -> dbus_we = 1, be = 4'b1100, wdata = 0xABCDABCD, addr = 0xC00. WB record = {0, 0, SH}.
5. LW at addr 0x4002 -> fault pulses one cycle, dbus_req never rises, stall = 0, wb_params_out = {0, 0, NONE}.
6. ALU op (NONE, rd 7, alu_result 0x55) immediately after a completed load -> passes through in the cycle after DONE with stall = 0; no bus activity.
